jtframe_pocket_dwnld: RTL and testbench

//  Sequences Pocket bridge ROM-download writes into the JTFRAME byte-wide ioctl port.

---
 rtl/jtframe_pocket_pkg.sv | 17 +
 rtl/jtframe_pocket_dwnld_fifo.sv | 61 ++++++
 rtl/jtframe_pocket_dwnld.sv | 175 +++++++++++++++++
 tb/tb_jtframe_pocket_dwnld.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_pocket_pkg.sv
// Shared definitions for the Pocket download sequencer: FSM encoding,
// default bridge command page and the slot index that carries core_mod.
package jtframe_pocket_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } st_t;

   // Bridge words in this page are commands, not ROM data
   localparam logic [7:0] SKIP_PAGE_DEF  = 8'hF8;
   // Slot whose first byte sets core_mod
   localparam logic [7:0] CORE_MOD_INDEX = 8'd1;

endpackage

// File: rtl/jtframe_pocket_dwnld_fifo.sv
// Small synchronous word FIFO with registered full/empty flags.
// Push and pop may happen in the same cycle; the caller only pushes when
// there is room (or when a pop frees a slot in that cycle).
module jtframe_pocket_dwnld_fifo #(
   parameter int DW = 63,
   parameter int AW = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_data,
   output logic          o_full,
   output logic          o_empty
);

   localparam int             DEPTH = 1 << AW;
   localparam logic [AW-1:0]  P_ONE = 1;
   localparam logic [AW:0]    C_ONE = 1;
   localparam logic [AW:0]    C_MAX = DEPTH[AW:0];

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt, w_cnt_nxt;
   logic          r_full, r_empty;

   // Occupancy after this cycle's push/pop
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_push && !i_pop)      w_cnt_nxt = r_cnt + C_ONE;
      else if (!i_push && i_pop) w_cnt_nxt = r_cnt - C_ONE;
   end

   // Storage array, no reset needed: only read when non-empty
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wp] <= i_data;
   end

   // Pointers, count and registered flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (i_push) r_wp <= r_wp + P_ONE;
         if (i_pop)  r_rp <= r_rp + P_ONE;
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == C_MAX);
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   assign o_data  = r_mem[r_rp];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/jtframe_pocket_dwnld.sv
// Pocket bridge ROM download -> JTFRAME byte-wide ioctl sequencer.
// Queues 32-bit bridge words and emits them big-endian, one ioctl_wr per
// byte, pacing each byte on the loader's prog_rdy acknowledge.
// Optional feature macro: JTFRAME_POCKET_CORE_MOD_EN enables capture of
// core_mod from the first byte of slot index 1.
module jtframe_pocket_dwnld
   import jtframe_pocket_pkg::*;
#(
   parameter int         AW        = 25,
   parameter int         FIFO_AW   = 2,
   parameter logic [7:0] SKIP_PAGE = SKIP_PAGE_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_wr_in,
   input  logic [31:0]   i_wr_addr,
   input  logic [31:0]   i_wr_data,
   input  logic [7:0]    i_slot_id,
   input  logic          i_slot_done,
   input  logic          i_prog_rdy,
   output logic [AW-1:0] o_ioctl_addr,
   output logic [7:0]    o_ioctl_dout,
   output logic          o_ioctl_wr,
   output logic [7:0]    o_ioctl_index,
   output logic          o_downloading,
   output logic          o_ovf,
   output logic [6:0]    o_core_mod
);

   // Queue entry: {slot, word address, data}
   localparam int            EW       = 8 + (AW - 2) + 32;
   localparam logic [AW-1:0] ADDR_ONE = 1;

   st_t            r_state, w_next;
   logic           w_push_req, w_push_ok, w_pop, w_full, w_empty, w_clr;
   logic [EW-1:0]  w_push_data, w_q;
   logic [7:0]     w_q_slot;
   logic [AW-3:0]  w_q_waddr;
   logic [31:0]    w_q_data;
   logic           w_unused_addr;

   logic [23:0]    r_shift;
   logic [1:0]     r_cnt;
   logic [AW-1:0]  r_addr;
   logic [7:0]     r_dout, r_index;
   logic           r_wr, r_dl, r_done_pend, r_ovf;

   // Upper address bits other than the page are meaningless here
   assign w_unused_addr = ^i_wr_addr;

   assign w_push_req  = i_wr_in && (i_wr_addr[31:24] != SKIP_PAGE);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept
   assign w_push_ok   = w_push_req && (!w_full || w_pop);
   assign w_push_data = {i_slot_id, i_wr_addr[AW-3:0], i_wr_data};

   assign w_q_slot  = w_q[EW-1 -: 8];
   assign w_q_waddr = w_q[32 +: (AW-2)];
   assign w_q_data  = w_q[31:0];

   jtframe_pocket_dwnld_fifo #(
      .DW (EW),
      .AW (FIFO_AW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push_ok),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_q),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-state logic; the pop happens in LOAD
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         ST_IDLE:  if (!w_empty) w_next = ST_LOAD;
         ST_LOAD: begin
            w_pop  = 1'b1;
            w_next = ST_ISSUE;
         end
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT: begin
            if (i_prog_rdy) begin
               if (r_cnt != 2'd3) w_next = ST_ISSUE;
               else if (!w_empty) w_next = ST_LOAD;
               else               w_next = ST_IDLE;
            end
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Byte shifter; ioctl outputs only change when a new byte is issued
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_dout  <= '0;
         r_index <= '0;
         r_wr    <= 1'b0;
      end else begin
         r_wr <= (w_next == ST_ISSUE);
         if (r_state == ST_LOAD) begin
            r_shift <= w_q_data[23:0];
            r_cnt   <= 2'd0;
            r_dout  <= w_q_data[31:24];
            r_addr  <= {w_q_waddr, 2'b00};
            r_index <= w_q_slot;
         end else if (r_state == ST_WAIT && i_prog_rdy && r_cnt != 2'd3) begin
            r_shift <= {r_shift[15:0], 8'h00};
            r_cnt   <= r_cnt + 2'd1;
            r_dout  <= r_shift[23:16];
            r_addr  <= r_addr + ADDR_ONE;
         end
      end
   end

   // Download end only once everything queued has been emitted
   assign w_clr = r_done_pend && w_empty && (r_state == ST_IDLE) && !w_push_ok;

   // downloading / done_pend / sticky overflow
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dl        <= 1'b0;
         r_done_pend <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_push_ok)  r_dl <= 1'b1;
         else if (w_clr) r_dl <= 1'b0;
         if (i_slot_done) r_done_pend <= 1'b1;
         else if (w_clr)  r_done_pend <= 1'b0;
         if (w_push_req && !w_push_ok) r_ovf <= 1'b1;
      end
   end

`ifdef JTFRAME_POCKET_CORE_MOD_EN
   logic [6:0] r_core_mod;
   logic       r_cm_done;

   // Capture core_mod from the first index-1 byte of each download
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_core_mod <= '0;
         r_cm_done  <= 1'b0;
      end else if (w_push_ok && !r_dl) begin
         r_cm_done  <= 1'b0;
      end else if (r_wr && r_index == CORE_MOD_INDEX && !r_cm_done) begin
         r_core_mod <= r_dout[6:0];
         r_cm_done  <= 1'b1;
      end
   end

   assign o_core_mod = r_core_mod;
`else
   assign o_core_mod = 7'd0;
`endif

   assign o_ioctl_addr  = r_addr;
   assign o_ioctl_dout  = r_dout;
   assign o_ioctl_wr    = r_wr;
   assign o_ioctl_index = r_index;
   assign o_downloading = r_dl;
   assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Directed bench for jtframe_pocket_dwnld: latency, byte order, skip page,
// overflow, done ordering, reset abort and core_mod capture.
module tb_jtframe_pocket_dwnld;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_in = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [7:0]  slot_id = '0;
   logic        slot_done = 1'b0;
   logic        rdy_man = 1'b0;
   logic        rdy_auto = 1'b0;
   logic        auto_en = 1'b0;
   logic        prog_rdy;

   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wr;
   logic [7:0]  ioctl_index;
   logic        downloading;
   logic        ovf;
   logic [6:0]  core_mod;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  q_dout[$];
   logic [24:0] q_addr[$];

`ifdef JTFRAME_POCKET_CORE_MOD_EN
   localparam logic [6:0] EXP_CM = 7'h05;
`else
   localparam logic [6:0] EXP_CM = 7'h00;
`endif

   assign prog_rdy = rdy_man | rdy_auto;

   always #5 clk = ~clk;

   jtframe_pocket_dwnld dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_wr_in       (wr_in),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .i_slot_id     (slot_id),
      .i_slot_done   (slot_done),
      .i_prog_rdy    (prog_rdy),
      .o_ioctl_addr  (ioctl_addr),
      .o_ioctl_dout  (ioctl_dout),
      .o_ioctl_wr    (ioctl_wr),
      .o_ioctl_index (ioctl_index),
      .o_downloading (downloading),
      .o_ovf         (ovf),
      .o_core_mod    (core_mod)
   );

   // Record every emitted byte
   always @(negedge clk) begin
      if (ioctl_wr) begin
         q_dout.push_back(ioctl_dout);
         q_addr.push_back(ioctl_addr);
      end
   end

   // Loader model: acknowledge two cycles after each strobe
   initial begin
      forever begin
         @(negedge clk);
         rdy_auto = 1'b0;
         if (auto_en && ioctl_wr) begin
            repeat (2) @(negedge clk);
            rdy_auto = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] a, input logic [31:0] d);
      wr_addr = a;
      wr_data = d;
      wr_in   = 1'b1;
      tick();
      wr_in   = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int k = 0;
      while (int'(q_dout.size()) < n && k < 300) begin
         tick();
         k++;
      end
      chk(tag, 32'(q_dout.size()), 32'(n));
   endtask

   task automatic clr_q();
      q_dout.delete();
      q_addr.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr"},    32'(ioctl_wr),    32'd0);
      chk({tag, "_addr"},  32'(ioctl_addr),  32'd0);
      chk({tag, "_dout"},  32'(ioctl_dout),  32'd0);
      chk({tag, "_index"}, 32'(ioctl_index), 32'd0);
      chk({tag, "_dl"},    32'(downloading), 32'd0);
      chk({tag, "_ovf"},   32'(ovf),         32'd0);
      chk({tag, "_cm"},    32'(core_mod),    32'd0);
   endtask

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e_cyc, f_cyc, bytes_at_fall;
      logic dl_at_e;

      // Reset state
      repeat (3) tick();
      chk_zero("rst");
      rst_n = 1'b1;
      tick();

      // Single word: latency and big-endian byte order
      auto_en = 1'b1;
      clr_q();
      send_word(32'h0000_0010, 32'hA1B2C3D4);
      chk("lat_n0", 32'(ioctl_wr), 32'd0);
      tick();
      chk("lat_n1", 32'(ioctl_wr), 32'd0);
      tick();
      chk("lat_n2", 32'(ioctl_wr), 32'd1);
      chk("w1_dl", 32'(downloading), 32'd1);
      wait_bytes(4, "w1_cnt");
      repeat (4) tick();
      chk("w1_b0", 32'(q_dout[0]), 32'hA1);
      chk("w1_a0", 32'(q_addr[0]), 32'h40);
      chk("w1_b1", 32'(q_dout[1]), 32'hB2);
      chk("w1_a1", 32'(q_addr[1]), 32'h41);
      chk("w1_b2", 32'(q_dout[2]), 32'hC3);
      chk("w1_a2", 32'(q_addr[2]), 32'h42);
      chk("w1_b3", 32'(q_dout[3]), 32'hD4);
      chk("w1_a3", 32'(q_addr[3]), 32'h43);
      chk("w1_hold_d", 32'(ioctl_dout), 32'hD4);
      chk("w1_hold_a", 32'(ioctl_addr), 32'h43);
      chk("w1_only4", 32'(q_dout.size()), 32'd4);
      slot_done = 1'b1;
      tick();
      slot_done = 1'b0;
      tick();
      chk("w1_dl_clr", 32'(downloading), 32'd0);

      // Command page is never queued
      clr_q();
      send_word(32'hF800_0000, 32'hDEADBEEF);
      repeat (8) tick();
      chk("skip_bytes", 32'(q_dout.size()), 32'd0);
      chk("skip_dl", 32'(downloading), 32'd0);

      // Overflow: loader stalled, six words back to back
      auto_en = 1'b0;
      clr_q();
      for (int k = 0; k < 6; k++) begin
         wr_addr = 32'h100 + 32'(k);
         wr_data = 32'h01020304 + 32'(k) * 32'h10101010;
         wr_in   = 1'b1;
         tick();
      end
      wr_in = 1'b0;
      repeat (3) tick();
      chk("ovf_flag", 32'(ovf), 32'd1);
      chk("ovf_stall", 32'(q_dout.size()), 32'd1);
      chk("ovf_dl", 32'(downloading), 32'd1);
      rdy_man = 1'b1;
      wait_bytes(20, "ovf_cnt");
      repeat (12) tick();
      rdy_man = 1'b0;
      chk("ovf_exact20", 32'(q_dout.size()), 32'd20);
      chk("ovf_b0", 32'(q_dout[0]), 32'h01);
      chk("ovf_a0", 32'(q_addr[0]), 32'h400);
      chk("ovf_b16", 32'(q_dout[16]), 32'h41);
      chk("ovf_a16", 32'(q_addr[16]), 32'h410);
      chk("ovf_b19", 32'(q_dout[19]), 32'h44);
      chk("ovf_sticky", 32'(ovf), 32'd1);
      slot_done = 1'b1;
      tick();
      slot_done = 1'b0;
      tick();
      chk("ovf_dl_clr", 32'(downloading), 32'd0);

      // Done ordering: slot_done while two words pending
      auto_en = 1'b1;
      clr_q();
      send_word(32'h200, 32'h0A0B0C0D);
      send_word(32'h201, 32'h1A1B1C1D);
      slot_done = 1'b1;
      tick();
      slot_done = 1'b0;
      chk("done_dl_hi", 32'(downloading), 32'd1);
      e_cyc = -1;
      f_cyc = -1;
      dl_at_e = 1'b0;
      bytes_at_fall = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk);
         #1;
         if (prog_rdy && q_dout.size() == 8 && e_cyc < 0) begin
            e_cyc   = c;
            dl_at_e = downloading;
         end
         if (!downloading) begin
            f_cyc = c;
            bytes_at_fall = q_dout.size();
            break;
         end
      end
      chk("done_dl_at_ack", 32'(dl_at_e), 32'd1);
      chk("done_lag", 32'(f_cyc - e_cyc), 32'd1);
      chk("done_bytes", 32'(bytes_at_fall), 32'd8);
      chk("done_b7", 32'(q_dout[7]), 32'h1D);
      tick();

      // Reset abort in WAIT of byte 2
      auto_en = 1'b0;
      repeat (6) tick();
      clr_q();
      send_word(32'h20, 32'h11223344);
      wait_bytes(1, "abort_b0");
      rdy_man = 1'b1;
      tick();
      rdy_man = 1'b0;
      repeat (2) tick();
      chk("issue_rdy_ignored", 32'(q_dout.size()), 32'd1);
      rdy_man = 1'b1;
      tick();
      rdy_man = 1'b0;
      tick();
      chk("abort_b1_cnt", 32'(q_dout.size()), 32'd2);
      chk("abort_b1_d", 32'(ioctl_dout), 32'h22);
      chk("abort_b1_a", 32'(ioctl_addr), 32'h81);
      rst_n = 1'b0;
      #1;
      chk_zero("abort");
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      auto_en = 1'b1;
      clr_q();
      send_word(32'h30, 32'h55667788);
      wait_bytes(4, "restart_cnt");
      chk("restart_b0", 32'(q_dout[0]), 32'h55);
      chk("restart_a0", 32'(q_addr[0]), 32'hC0);
      chk("restart_b3", 32'(q_dout[3]), 32'h88);
      chk("restart_a3", 32'(q_addr[3]), 32'hC3);
      repeat (6) tick();

      // core_mod from first byte of slot 1
      clr_q();
      slot_id = 8'd1;
      send_word(32'h40, 32'h05AABBCC);
      wait_bytes(4, "cm_cnt");
      repeat (4) tick();
      chk("cm_index", 32'(ioctl_index), 32'd1);
      chk("cm_first", 32'(core_mod), 32'(EXP_CM));
      send_word(32'h41, 32'h07000000);
      wait_bytes(8, "cm_cnt2");
      repeat (4) tick();
      chk("cm_kept", 32'(core_mod), 32'(EXP_CM));
      slot_id = 8'd0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
